fetch_sequencer: RTL

Reads and advances the program counter, the consuming side of the PC latch. It issues instruction-fetch requests to instruction memory with one request in flight, and buffers returned instructions with their PCs in a small queue. It hands them to decode over a valid/ready handshake, and applies branch/jump redirects from execute, including flushing the queue and discarding stale responses. It sits between the PC/next-PC path and the decode stage.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the instruction-fetch path.
package pc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries with flush; head reads as zero when empty.
module fetch_queue
  import pc_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2,
  localparam int CW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  fetch_entry_t  mem [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(QUEUE_DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Masked so dec_pc/dec_instr read zero out of reset without clearing the array.
  assign head = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_entry;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC register and request FSM: one outstanding imem request, queued
// responses to decode, and redirect handling with stale-response discard.
module fetch_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  input  logic        dec_ready,
  output logic [31:0] pc_out
);

  localparam int QCW = $clog2(QUEUE_DEPTH + 1);

  fetch_state_t   state_reg;
  logic [31:0]    pc_reg;
  logic [31:0]    req_pc_reg;
  logic           req_en_reg;

  logic           req_fire;
  logic           q_push;
  logic           q_pop;
  logic           q_empty;
  logic           q_full;
  logic [QCW-1:0] q_count;
  fetch_entry_t   q_head;
  fetch_entry_t   q_push_entry;

  // req_en_reg keeps the request low while reset is held.
  assign imem_req_valid = req_en_reg && (state_reg == FS_REQ) &&
                          (q_count < QCW'(QUEUE_DEPTH));
  assign imem_req_addr  = pc_reg;
  assign pc_out         = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign q_push       = (state_reg == FS_WAIT) && imem_rsp_valid && !redirect_valid;
  assign q_push_entry = '{pc: req_pc_reg, instr: imem_rsp_data};
  assign q_pop        = dec_valid && dec_ready;

  assign dec_valid = !q_empty;
  assign dec_pc    = q_head.pc;
  assign dec_instr = q_head.instr;

  fetch_queue #(
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (q_push),
    .push_entry (q_push_entry),
    .pop        (q_pop),
    .flush      (redirect_valid),
    .head       (q_head),
    .count      (q_count),
    .empty      (q_empty),
    .full       (q_full)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= FS_REQ;
      pc_reg     <= RESET_PC;
      req_pc_reg <= RESET_PC;
      req_en_reg <= 1'b0;
    end else begin
      req_en_reg <= 1'b1;
      if (req_fire) req_pc_reg <= pc_reg;

      if (redirect_valid)  pc_reg <= align_pc(redirect_pc);
      else if (req_fire)   pc_reg <= pc_reg + PC_INCR;

      // A redirect turns the in-flight response stale unless it lands this very cycle.
      case (state_reg)
        FS_REQ: begin
          if (req_fire) state_reg <= redirect_valid ? FS_DROP : FS_WAIT;
        end
        FS_WAIT: begin
          if (imem_rsp_valid)      state_reg <= FS_REQ;
          else if (redirect_valid) state_reg <= FS_DROP;
        end
        FS_DROP: begin
          if (imem_rsp_valid) state_reg <= FS_REQ;
        end
        default: state_reg <= FS_REQ;
      endcase
    end
  end

  a_no_rsp_in_req: assert property (@(posedge clock) disable iff (!reset)
    !(imem_rsp_valid && state_reg == FS_REQ));

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(q_push && q_full && !q_pop));

endmodule
